// File: rtl/gshare_pht_pkg.sv
// Shared IFU definitions for the gshare direction predictor: default sizes,
// counter-init derivation and the gshare index hash reused by recovery logic.
package gshare_pht_pkg;

  localparam int DEF_IDX_W = 10;
  localparam int DEF_CTR_W = 2;
  localparam int DEF_GHR_W = 10;

  // Widest index/history the hash helper handles; callers cast in and out.
  localparam int HASH_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

  // Weakly not-taken: one below the taken threshold.
  function automatic int ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // History is zero-extended or truncated to the index width before the XOR.
  function automatic logic [HASH_W-1:0] gshare_idx(input logic [HASH_W-1:0] pc_idx,
                                                   input logic [HASH_W-1:0] ghr,
                                                   input int                idx_w);
    logic [HASH_W-1:0] r;
    for (int i = 0; i < HASH_W; i++) begin
      r[i] = (i < idx_w) ? (pc_idx[i] ^ ghr[i]) : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_pht_sat_ctr.sv
// Combinational saturating up/down step for one CTR_W-bit prediction counter.
module pht_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] nxt
);

  // NOTE: assign every always_comb output a default first so no path leaves
  // it unassigned; a missing default infers a latch.
  always_comb begin
    nxt = ctr;
    if (inc) begin
      if (ctr != '1) nxt = ctr + 1'b1;
    end else begin
      if (ctr != '0) nxt = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: registered prediction with speculative GHR,
// execute-stage update/recovery, and a post-reset sweep that initialises all counters.
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int GHR_W    = DEF_GHR_W,
  parameter int CTR_INIT = ctr_init(CTR_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_pc_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_pc_idx,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic             init_busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(CTR_INIT);

  pht_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt;
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_shift, ghr_restore, ghr_spec;
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [CTR_W-1:0] upd_cur, upd_next;
  logic             running, mispred, accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;
  logic [CTR_W-1:0] pht [DEPTH];

  assign running   = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);
  assign mispred   = running & upd_valid & upd_mispred;
  assign accept    = running & pred_req & ~mispred;

  if (GHR_W == 1) begin : g_ghr_one
    assign ghr_shift   = pred_taken;
    assign ghr_restore = upd_taken;
  end else begin : g_ghr_many
    assign ghr_shift   = {ghr[GHR_W-2:0], pred_taken};
    assign ghr_restore = {upd_ghr[GHR_W-2:0], upd_taken};
  end

  // The in-flight prediction's direction is folded in before it reaches the GHR.
  assign ghr_spec = pred_valid ? ghr_shift : ghr;

  assign pred_idx = IDX_W'(gshare_idx(HASH_W'(pred_pc_idx), HASH_W'(ghr_spec), IDX_W));
  assign upd_idx  = IDX_W'(gshare_idx(HASH_W'(upd_pc_idx), HASH_W'(upd_ghr), IDX_W));
  assign upd_cur  = pht[upd_idx];

  pht_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr (upd_cur),
    .inc (upd_taken),
    .nxt (upd_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_cnt == '1) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sweep_cnt  <= '0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      state_q    <= state_d;
      if (state_q == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
      ghr        <= mispred ? ghr_restore : ghr_spec;
      pred_valid <= accept;
      if (accept) begin
        pred_taken <= pht[pred_idx][CTR_W-1];
        pred_ghr   <= ghr_spec;
      end
    end
  end

  // Sweep writes take the single write port while INIT is active.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_next;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_cnt;
      wr_data = INIT_VAL;
    end else if (upd_valid) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: the counter array has no reset; the INIT sweep gives it defined
  // contents, which keeps it a plain flop/RAM array without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed scenarios plus randomized traffic
// compared against an array-based behavioural predictor model.
module tb_gshare_pht;

  localparam int IDX_W    = 10;
  localparam int CTR_W    = 2;
  localparam int GHR_W    = 10;
  localparam int DEPTH    = 1 << IDX_W;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_INIT = (1 << (CTR_W - 1)) - 1;
  localparam int TAKEN_TH = 1 << (CTR_W - 1);
  localparam int GMASK    = (1 << GHR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pred_req = 1'b0;
  logic [IDX_W-1:0] pred_pc_idx = '0;
  logic             pred_valid;
  logic             pred_taken;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_pc_idx = '0;
  logic [GHR_W-1:0] upd_ghr = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispred = 1'b0;
  logic             init_busy;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int m_ctr [DEPTH];
  int m_ghr, m_pg, m_sweep;
  bit m_busy, m_pv, m_pt;

  gshare_pht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_req    (pred_req),
    .pred_pc_idx (pred_pc_idx),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_ghr    (pred_ghr),
    .upd_valid   (upd_valid),
    .upd_pc_idx  (upd_pc_idx),
    .upd_ghr     (upd_ghr),
    .upd_taken   (upd_taken),
    .upd_mispred (upd_mispred),
    .init_busy   (init_busy)
  );

  always #5 clk = ~clk;

  function automatic int m_spec();
    return m_pv ? (((m_ghr << 1) | int'(m_pt)) & GMASK) : m_ghr;
  endfunction

  function automatic int hash(input int pc, input int g);
    return (pc ^ g) & (DEPTH - 1);
  endfunction

  task automatic model_reset();
    m_busy = 1'b1; m_sweep = 0; m_ghr = 0; m_pv = 1'b0; m_pt = 1'b0; m_pg = 0;
  endtask

  task automatic drive(input bit req, input int pc, input bit uv, input int upc,
                       input int ughr, input bit ut, input bit um);
    pred_req    = req;
    pred_pc_idx = IDX_W'(pc);
    upd_valid   = uv;
    upd_pc_idx  = IDX_W'(upc);
    upd_ghr     = GHR_W'(ughr);
    upd_taken   = ut;
    upd_mispred = um;
  endtask

  // Advance the model by one clock from the currently driven inputs, then clock the DUT.
  task automatic tick();
    int spec, pidx, uidx;
    bit mis;
    if (m_busy) begin
      m_ctr[m_sweep] = CTR_INIT;
      m_sweep++;
      if (m_sweep == DEPTH) m_busy = 1'b0;
      m_pv = 1'b0;
    end else begin
      spec = m_spec();
      mis  = upd_valid && upd_mispred;
      pidx = hash(int'(pred_pc_idx), spec);
      if (pred_req && !mis) begin
        m_pt = m_ctr[pidx] >= TAKEN_TH;
        m_pg = spec;
        m_pv = 1'b1;
      end else begin
        m_pv = 1'b0;
      end
      if (upd_valid) begin
        uidx = hash(int'(upd_pc_idx), int'(upd_ghr));
        if (upd_taken) m_ctr[uidx] = (m_ctr[uidx] == CTR_MAX) ? CTR_MAX : m_ctr[uidx] + 1;
        else           m_ctr[uidx] = (m_ctr[uidx] == 0) ? 0 : m_ctr[uidx] - 1;
      end
      m_ghr = mis ? (((int'(upd_ghr) << 1) | int'(upd_taken)) & GMASK) : spec;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Predict so that the table entry actually read is `entry`.
  task automatic predict_entry(input int entry);
    drive(1, hash(entry, m_spec()), 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic check_init_window(input string tag);
    for (int c = 0; c < DEPTH; c++) begin
      tick();
      tests++;
      if (init_busy !== m_busy || pred_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle %0d: init_busy=%b pred_valid=%b, required init_busy=%b pred_valid=0",
                 tag, c, init_busy, pred_valid, m_busy);
      end
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tests++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_ghr !== '0 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: valid=%b taken=%b ghr=%h busy=%b, required 0 0 000 1",
               pred_valid, pred_taken, pred_ghr, init_busy);
    end
    rst = 1'b0;
    drive(1, 'h155, 0, 0, 0, 0, 0);
    check_init_window("init_sweep");
    predict_entry('h155);
    tests++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_ghr !== '0) begin
      fails++;
      $display("FAIL first_pred: valid=%b taken=%b ghr=%h, required 1 0 000",
               pred_valid, pred_taken, pred_ghr);
    end
  endtask

  task automatic test_saturation();
    repeat (5) begin drive(0, 0, 1, 'h010, 0, 1, 0); tick(); end
    predict_entry('h010);
    tests++;
    if (pred_taken !== 1'b1 || m_ctr['h010] != CTR_MAX) begin
      fails++;
      $display("FAIL sat_up: taken=%b model_ctr=%0d, required taken=1 ctr=%0d", pred_taken, m_ctr['h010], CTR_MAX);
    end
    repeat (5) begin drive(0, 0, 1, 'h010, 0, 0, 0); tick(); end
    predict_entry('h010);
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL sat_down: taken=%b, required 0", pred_taken);
    end
    // From a floor of 0, two increments must reach the taken threshold.
    repeat (2) begin drive(0, 0, 1, 'h010, 0, 1, 0); tick(); end
    predict_entry('h010);
    tests++;
    if (pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL sat_no_wrap: taken=%b, required 1", pred_taken);
    end
    idle();
  endtask

  task automatic test_spec_ghr();
    int exp_ghr [3];
    exp_ghr = '{'h000, 'h001, 'h003};
    drive(0, 0, 1, 'h3FF, 0, 0, 1);
    tick();
    foreach (exp_ghr[k]) begin
      repeat (2) begin drive(0, 0, 1, 'h2A0 ^ exp_ghr[k], 0, 1, 0); tick(); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 'h2A0, 0, 0, 0, 0, 0);
      tick();
      tests++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_ghr !== GHR_W'(exp_ghr[k])) begin
        fails++;
        $display("FAIL spec_ghr[%0d]: valid=%b taken=%b ghr=%h, required 1 1 %h",
                 k, pred_valid, pred_taken, pred_ghr, exp_ghr[k]);
      end
    end
    idle();
  endtask

  task automatic test_mispredict();
    drive(0, 0, 1, 'h100, 'h07F, 1, 1);
    tick();
    drive(1, 'h155, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (pred_valid !== 1'b1 || pred_ghr !== GHR_W'('h0FF)) begin
      fails++;
      $display("FAIL ghr_restore: valid=%b ghr=%h, required 1 0ff", pred_valid, pred_ghr);
    end
    // Mispredict with a concurrent request while a prediction is still presented.
    drive(1, 'h155, 1, 'h101, 'h012, 1, 1);
    tick();
    tests++;
    if (pred_valid !== 1'b0) begin
      fails++;
      $display("FAIL mispred_drop: valid=%b, required 0", pred_valid);
    end
    drive(1, 'h155, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (pred_valid !== 1'b1 || pred_ghr !== GHR_W'('h025) || pred_taken !== m_pt) begin
      fails++;
      $display("FAIL mispred_recover: valid=%b ghr=%h taken=%b, required 1 025 %b",
               pred_valid, pred_ghr, pred_taken, m_pt);
    end
    idle();
  endtask

  task automatic test_collision();
    drive(0, 0, 1, 'h3FF, 0, 0, 1);
    tick();
    drive(1, 'h0C3, 1, 'h0C3, 0, 1, 0);
    tick();
    tests++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL collision_old: valid=%b taken=%b, required 1 0", pred_valid, pred_taken);
    end
    predict_entry('h0C3);
    tests++;
    if (pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL collision_write: taken=%b, required 1", pred_taken);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 4) < 2, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, GMASK), $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0);
      tick();
      tests++;
      if (pred_valid !== m_pv || init_busy !== 1'b0) begin
        fails++;
        $display("FAIL rand_valid[%0d]: valid=%b busy=%b, required %b 0", n, pred_valid, init_busy, m_pv);
      end else if (m_pv && (pred_taken !== m_pt || pred_ghr !== GHR_W'(m_pg))) begin
        fails++;
        $display("FAIL rand_pred[%0d]: taken=%b ghr=%h, required %b %h", n, pred_taken, pred_ghr, m_pt, m_pg);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 1, 'h200, 'h155, 1, 1);
    tick();
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tests++;
    if (init_busy !== 1'b1 || pred_valid !== 1'b0 || pred_ghr !== '0) begin
      fails++;
      $display("FAIL midreset_values: busy=%b valid=%b ghr=%h, required 1 0 000", init_busy, pred_valid, pred_ghr);
    end
    rst = 1'b0;
    drive(1, 'h0C3, 1, 'h0C3, 0, 1, 1);
    check_init_window("midreset_sweep");
    for (int e = 0; e < DEPTH; e++) begin
      predict_entry(e);
      tests++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_ghr !== '0) begin
        fails++;
        $display("FAIL midreset_entry[%0h]: valid=%b taken=%b ghr=%h, required 1 0 000",
                 e, pred_valid, pred_taken, pred_ghr);
      end
    end
    // Exactly CTR_INIT: one taken update must cross the threshold.
    drive(0, 0, 1, 'h0C3, 0, 1, 0);
    tick();
    predict_entry('h0C3);
    tests++;
    if (pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL midreset_init_val: taken=%b, required 1", pred_taken);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_spec_ghr();
    test_mispredict();
    test_collision();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
